// File: rtl/machine_result_serializer.sv
// Buffers 12-bit {tag, value} result words in a small FIFO and streams each one
// out as a header byte followed by a value byte over a valid/ready byte link.
module machine_result_serializer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic [11:0]       in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    state_t            state, state_next;
    logic [11:0]       mem [DEPTH];
    logic [ADDR_W:0]   wptr, rptr;
    logic [11:0]       hold, hold_next;
    logic              full, empty, push, pop;
    logic [7:0]        byte_next;
    logic              valid_next;

    function automatic logic [7:0] encode_byte(input state_t s, input logic [11:0] w);
        case (s)
            HDR:     encode_byte = {1'b1, 3'b000, w[11:8]};
            DATA:    encode_byte = w[7:0];
            default: encode_byte = 8'h00;
        endcase
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full     = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign empty    = (wptr == rptr);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign level    = wptr - rptr;

    always_comb begin
        state_next = state;
        hold_next  = hold;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    hold_next  = mem[rptr[ADDR_W-1:0]];
                    state_next = HDR;
                end
            end
            HDR: begin
                if (out_ready) state_next = DATA;
            end
            DATA: begin
                if (out_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        hold_next  = mem[rptr[ADDR_W-1:0]];
                        state_next = HDR;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        valid_next = (state_next != IDLE);
        byte_next  = encode_byte(state_next, hold_next);
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state     <= IDLE;
            hold      <= 12'h000;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            hold      <= hold_next;
            out_valid <= valid_next;
            out_byte  <= byte_next;
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge system1000) begin
        if (push) mem[wptr[ADDR_W-1:0]] <= in_word;
    end

endmodule
